sync_filter_multi: RTL and testbench
====================================

# sync_filter_multi

Parametrised multi-channel synchroniser for bringing asynchronous, quasi-static control and status signals into a single clock domain of the JESD204B RX path (e.g. SYSREF-qualified enables, lane-status flags, SYNC~ feedback). Each channel gets a configurable-depth flop chain with per-channel reset value. It adds an optional stability (deglitch) filter and registered-edge rise and fall pulse outputs, replacing ad-hoc edge detectors downstream of plain two-flop synchronisers.

## Interface
- `WIDTH`, default 1: number of independent channels.
- `STAGES`, default 2: synchroniser flops per channel. Must be ≥2; elaboration error otherwise.
- `FILT_CYCLES`, default 0: consecutive synchronised cycles a new level must persist before it reaches the output. 0 bypasses the filter.
- `RST_VAL`, default `'0`, `WIDTH` bits: per-channel reset level of the chain, the filtered output and the edge history.
- `clk_i` input, 1 bit: destination-domain clock. Single clock, all logic on the rising edge.
- `rst_ni` input, 1 bit: reset, asynchronous and active-low.
- `signal_i` input, `WIDTH` bits: asynchronous inputs.
- `signal_o` output, `WIDTH` bits: synchronised, filtered levels.
- `rise_o` output, `WIDTH` bits: one-cycle pulse when `signal_o[i]` goes 0→1.
- `fall_o` output, `WIDTH` bits: one-cycle pulse when `signal_o[i]` goes 1→0.

## Operation
- Per channel `i`, all logic is independent across channels.
- **Sync chain:** `sync[0..STAGES-1]`. `sync[0]` <= `signal_i[i]`, and `sync[n]` <= `sync[n-1]`. Let `s` = `sync[STAGES-1]`. Only `sync[0]` may sample an asynchronous signal; no logic between stages.
- **Filter, `FILT_CYCLES` = N ≥ 1:** filtered state `f` and counter `cnt`. `cnt` has width max(1, $clog2(N)) and range 0..N-1, never wraps.
  - If `s == f`: `cnt` <= 0.
  - Else if `cnt == N-1`: `f` <= `s`, `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - Any return of `s` to `f` before acceptance discards the partial count. A level must be stable for N consecutive synchronised cycles to be accepted.
- **Filter bypass, N = 0:** `f` is `s` (no extra register, no counter).
- `signal_o[i]` = `f`.
- **Edge detect:** register `prev` <= `signal_o[i]` every cycle.
  - `rise_o[i]` = `signal_o[i] & ~prev`.
  - `fall_o[i]` = `~signal_o[i] & prev`.
  - Both pulses come from registers only, with no path from `signal_i`.
- **Reset:** while `rst_ni` = 0, all of the following hold asynchronously, with no clock required:
  - every `sync` stage = `RST_VAL[i]`
  - `f` = `RST_VAL[i]`
  - `prev` = `RST_VAL[i]`
  - `cnt` = 0
- **Reset-derived output values:** `signal_o` = `RST_VAL`, `rise_o` = `fall_o` = 0. No pulse is emitted on reset entry or release.
- **Reset release:** deassertion is assumed synchronised externally. On the first edge after release, normal operation resumes with a zero count.

## Timing
- Let k be the rising edge at which `sync[0]` first captures a new level that then stays constant.
- `signal_o[i]` takes the new level immediately after edge k + STAGES + N − 1:
  - bypass: k + STAGES − 1
  - default, STAGES=2, N=0: k+1
- `rise_o`/`fall_o` are high for exactly the one cycle following that edge, then 0. One level change produces exactly one pulse.
- An input pulse spanning fewer than N sampling edges (after synchronisation) never reaches `signal_o` and produces no edge pulse. An input spanning exactly N edges is accepted.
- Simultaneous events on different channels are fully independent. `rise_o` and `fall_o` may both be non-zero in the same cycle on different bits, never on the same bit.
- Metastability: input-to-`sync[0]` sampling uncertainty is ±1 edge. Benches check latency with inputs changed away from the clock edge.

## Test plan
- **Reset hold:** WIDTH=4, STAGES=3, N=4, RST_VAL=4'b1010. Hold `rst_ni`=0 with `signal_i`=4'hF for 10 cycles.
  - Expect `signal_o`=4'b1010 and `rise_o`=`fall_o`=0 throughout.
  - Release with `signal_i`=4'b1010: no pulses for 20 cycles.
- **Step latency:** same config, ch0 0→1 captured at edge k.
  - Expect `signal_o[0]`=1 after edge k+6.
  - Expect `rise_o[0]`=1 for exactly the cycle after k+6, and other bits unchanged.
- **Glitch rejection:** same config.
  - ch0 high for 3 sampling edges, then low: `signal_o[0]` stays 0, no pulse.
  - Repeat with 4 edges: accepted, `signal_o[0]` high, single `rise_o[0]`.
  - A later 4-edge low excursion gives a single `fall_o[0]`.
- **Bypass:** STAGES=2, N=0, WIDTH=1, RST_VAL=0.
  - 0→1 captured at edge k gives `signal_o`=1 after edge k+1 plus a 1-cycle `rise_o`.
  - A 1-cycle input pulse aligned to the edge propagates as a 1-cycle output level.
- **Async reset mid-filter:** STAGES=3, N=4, `cnt` of ch0 at 2.
  - Assert `rst_ni` between clock edges: `signal_o` returns to RST_VAL with no clock edge.
  - After release, with the input held changed, acceptance occurs exactly at edge r+6, where r is the first sampling edge after release.
- **Channel independence:** WIDTH=4.
  - Toggle ch1 every cycle: ch1 never changes, no pulses.
  - In the same cycle, accept a rise on ch0 and a fall on ch3: `rise_o`=4'b0001 and `fall_o`=4'b1000 in the same cycle.

Source files
------------

// File: rtl/sync_filter_multi.sv
// Multi-channel synchroniser: per-channel flop chain, optional stability filter
// and register-derived rise/fall pulses for quasi-static async controls.
module sync_filter_multi #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      STAGES      = 2,
  parameter int unsigned      FILT_CYCLES = 0,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] signal_i,
  output logic [WIDTH-1:0] signal_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filter_multi: STAGES must be at least 2");
  end

  logic [WIDTH-1:0] filt_s;
  logic [WIDTH-1:0] prev_r;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [STAGES-1:0] sync_r;

    // Synchroniser chain: only sync_r[0] sees the asynchronous input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_r <= {STAGES{RST_VAL[i]}};
      end else begin
        sync_r <= {sync_r[STAGES-2:0], signal_i[i]};
      end
    end

    if (FILT_CYCLES == 0) begin : g_bypass
      assign filt_s[i] = sync_r[STAGES-1];
    end else begin : g_filt
      localparam int unsigned   CW      = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
      localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES - 1);
      logic [CW-1:0] cnt_r;
      logic          f_r;

      // Stability filter: a differing level must persist FILT_CYCLES cycles;
      // any return to the current level discards the partial count.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_r <= CW'(0);
          f_r   <= RST_VAL[i];
        end else if (sync_r[STAGES-1] == f_r) begin
          cnt_r <= CW'(0);
        end else if (cnt_r == CNT_MAX) begin
          cnt_r <= CW'(0);
          f_r   <= sync_r[STAGES-1];
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end

      assign filt_s[i] = f_r;
    end
  end

  // Edge history; reset to RST_VAL so no pulse appears on reset entry or exit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_r <= RST_VAL;
    end else begin
      prev_r <= filt_s;
    end
  end

  assign signal_o = filt_s;
  assign rise_o   = filt_s & ~prev_r;
  assign fall_o   = ~filt_s & prev_r;

endmodule

// File: tb/tb_sync_filter_multi.sv
// Scoreboard bench for sync_filter_multi: a filtered (3 stages, N=4) and a bypass
// (2 stages) instance share the stimulus and are compared against a history model.
module tb_sync_filter_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sig_in;
  logic [3:0] so0, ro0, fo0;
  logic [3:0] so1, ro1, fo1;

  always #5 clk = ~clk;

  sync_filter_multi #(.WIDTH(4), .STAGES(3), .FILT_CYCLES(4), .RST_VAL(4'b1010)) u_main (
    .clk_i(clk), .rst_ni(rst_n), .signal_i(sig_in),
    .signal_o(so0), .rise_o(ro0), .fall_o(fo0)
  );

  sync_filter_multi #(.WIDTH(4), .STAGES(2), .FILT_CYCLES(0), .RST_VAL(4'b0000)) u_byp (
    .clk_i(clk), .rst_ni(rst_n), .signal_i(sig_in),
    .signal_o(so1), .rise_o(ro1), .fall_o(fo1)
  );

  typedef struct packed {
    logic [3:0] s0, r0, f0, s1, r1, f1;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] hist [2][16];
  logic [3:0] fexp [2];
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic int stg(input int m);
    return (m == 0) ? 3 : 2;
  endfunction

  function automatic int nfilt(input int m);
    return (m == 0) ? 4 : 0;
  endfunction

  function automatic logic [3:0] rval(input int m);
    return (m == 0) ? 4'b1010 : 4'b0000;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at time %0t", name, act, want, $time);
    end
  endtask

  // Reference: output level changes once the last N synchronised samples all differ.
  task automatic model_step();
    exp_t       e;
    logic [3:0] fn, acc, rs, fl;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        for (int j = 0; j < 16; j++) hist[m][j] = rval(m);
        fexp[m] = rval(m);
        fn = rval(m);
        rs = 4'b0000;
        fl = 4'b0000;
      end else begin
        for (int j = 15; j > 0; j--) hist[m][j] = hist[m][j-1];
        hist[m][0] = sig_in;
        if (nfilt(m) == 0) begin
          fn = hist[m][stg(m)-1];
        end else begin
          acc = 4'b1111;
          for (int j = 0; j < nfilt(m); j++) acc = acc & (hist[m][stg(m)+j] ^ fexp[m]);
          fn = fexp[m] ^ acc;
        end
        rs = fn & ~fexp[m];
        fl = ~fn & fexp[m];
        fexp[m] = fn;
      end
      if (m == 0) begin
        e.s0 = fn; e.r0 = rs; e.f0 = fl;
      end else begin
        e.s1 = fn; e.r1 = rs; e.f1 = fl;
      end
    end
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: one expectation per edge, compared 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL scoreboard_empty: got no expectation, expected one at time %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("main_signal", so0, e.s0);
        chk("main_rise",   ro0, e.r0);
        chk("main_fall",   fo0, e.f0);
        chk("byp_signal",  so1, e.s1);
        chk("byp_rise",    ro1, e.r1);
        chk("byp_fall",    fo1, e.f1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #4;
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    sig_in = 4'hF;
    #1 rst_n = 1'b0;

    // Reset hold with opposing input, then quiet release.
    tick(10);
    sig_in = 4'b1010;
    tick(1);
    rst_n = 1'b1;
    tick(20);

    // Quasi-static random activity with mixed run lengths.
    repeat (400) begin
      tick(1);
      if ($urandom_range(0, 4) == 0) sig_in[$urandom_range(0, 3)] ^= 1'b1;
    end
    // Glitch-heavy random activity.
    repeat (50) begin
      tick(1);
      sig_in = 4'($urandom);
    end

    // Glitch rejection: 3-edge pulse, 4-edge pulse, 4-edge low excursion.
    sig_in = 4'b0000;
    tick(12);
    sig_in[0] = 1'b1;
    tick(3);
    sig_in[0] = 1'b0;
    tick(12);
    sig_in[0] = 1'b1;
    tick(4);
    tick(12);
    sig_in[0] = 1'b0;
    tick(4);
    sig_in[0] = 1'b1;
    tick(12);

    // Channel independence: ch1 chatters while ch0 rises and ch3 falls together.
    sig_in = 4'b1000;
    tick(12);
    for (int c = 0; c < 20; c++) begin
      sig_in[1] = ~sig_in[1];
      if (c == 5) begin
        sig_in[0] = 1'b1;
        sig_in[3] = 1'b0;
      end
      tick(1);
    end
    sig_in[1] = 1'b0;
    tick(12);

    // Async reset mid-filter, then acceptance timed from release.
    sig_in = 4'b1010;
    tick(12);
    sig_in[0] = 1'b1;
    tick(5);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_main_signal", so0, 4'b1010);
    chk("async_rst_main_rise",   ro0, 4'b0000);
    chk("async_rst_main_fall",   fo0, 4'b0000);
    chk("async_rst_byp_signal",  so1, 4'b0000);
    tick(2);
    rst_n = 1'b1;
    tick(15);

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
